dreg_shifter: RTL
=================

DREG_SHIFTER -- requirements
Module: dreg_shifter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, which sets the register width in bits (legal range 2..64).
REQ-002 The block SHALL derive localparam CNT_W = $clog2(WIDTH+1) as the burst-counter width.
REQ-003 Port clk  input  1  rising-edge clock; the only clock.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  clock enable; when 0, all state holds.
REQ-006 Port op  input  3  command: 000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 110 clear, 111 burst start.
REQ-007 Port d  input  WIDTH  parallel load data.
REQ-008 Port sin  input  1  serial fill bit for shl/shr and burst shifts.
REQ-009 Port len  input  CNT_W  burst shift count, sampled at burst start.
REQ-010 Port dir  input  1  burst direction, sampled at burst start: 0 left, 1 right.
REQ-011 Port q  output  WIDTH  register contents.
REQ-012 Port sout  output  1  bit expelled by the most recent shift or rotate (registered).
REQ-013 Port busy  output  1  high while a burst is in progress.
REQ-014 Port done  output  1  one-cycle pulse marking burst completion.

Function
REQ-015 The controller SHALL have two states: IDLE and BUSY.
REQ-016 In IDLE with en=1, the op SHALL take effect at the rising edge, as follows.
  - load: q<=d.
  - shl: q<={q[W-2:0],sin}, sout<=q[W-1].
  - shr: q<={sin,q[W-1:1]}, sout<=q[0].
  - rotl: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
  - rotr: q<={q[0],q[W-1:1]}, sout<=q[0].
  - clear: q<=0, sout<=0.
  - hold: no change.
REQ-017 Load and hold SHALL leave sout unchanged.
REQ-018 A burst start (op=111) in IDLE with en=1 SHALL do all of the following at that edge.
  - q<=d.
  - Latch dir.
  - remaining<=len.
  - If len>0: enter BUSY, busy=1 from the following cycle.
REQ-019 A burst start with len=0 SHALL load q, stay IDLE, and pulse done for the next cycle only.
REQ-020 In BUSY with en=1, each edge SHALL perform one shift in the latched direction, filling with sin, updating sout as for shl/shr, and decrementing remaining.
REQ-021 The edge that performs the shift with remaining=1 SHALL return to IDLE, clear busy and set done for exactly one cycle; latency from start edge to done is len+1 edges with en held 1.
REQ-022 In BUSY with en=0, q, sout, remaining and state SHALL hold; done SHALL stay 0.
REQ-023 In BUSY, op=110 with en=1 SHALL abort the burst: q<=0, sout<=0, IDLE, busy=0, and no done pulse.
REQ-024 In BUSY, every other op value SHALL be ignored.
REQ-025 done SHALL be 0 in every cycle not named in REQ-019 and REQ-021.
REQ-026 A len greater than WIDTH SHALL be honoured; excess shifts fill q entirely with sin.

Reset
REQ-027 rst_n=0 SHALL, asynchronously, force q=0, sout=0, busy=0, done=0, remaining=0 and state IDLE, including mid-burst.
REQ-028 The first edge after rst_n deasserts SHALL process inputs normally.

Structure
REQ-029 The op encodings and the state encoding SHALL live in shared package dreg_pkg.
REQ-030 The WIDTH-bit datapath (mux of load, shift, rotate and clear) SHALL be sub-module dreg_shift_core; the FSM and counter SHALL stay in dreg_shifter.

Verification (WIDTH=8)
REQ-031 load d=8'hA5, then rotl -> q=8'h4B, sout=1; then rotr -> q=8'hA5, sout=1.
REQ-032 burst d=8'h81, len=3, dir=0, sin=0, en=1 -> busy for 3 cycles, q=8'h08, sout=0, done pulses once on the 4th edge.
REQ-033 burst len=0, d=8'h3C -> q=8'h3C, busy never rises, done high for exactly one cycle.
REQ-034 burst len=4 with en=0 for 2 cycles mid-burst -> q frozen during the stall, done arrives 2 cycles later than with en=1.
REQ-035 op=110 during a burst -> q=0, busy=0 next cycle, no done pulse.
REQ-036 rst_n pulsed low mid-burst between clock edges -> q=0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dreg_pkg.sv
// Shared encodings for the dreg_shifter slice: command opcodes and controller states.
package dreg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROTL  = 3'b100,
    OP_ROTR  = 3'b101,
    OP_CLEAR = 3'b110,
    OP_BURST = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/dreg_shift_core.sv
// WIDTH-bit register datapath: load / shift / rotate / clear mux plus the
// registered expelled bit. The controller decides which command runs each cycle.
module dreg_shift_core
  import dreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  op_t              cmd,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of q; blocking here would chain the shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      sout <= 1'b0;
    end else begin
      case (cmd)
        OP_LOAD: q <= d;
        OP_SHL: begin
          q    <= {q[WIDTH-2:0], sin};
          sout <= q[WIDTH-1];
        end
        OP_SHR: begin
          q    <= {sin, q[WIDTH-1:1]};
          sout <= q[0];
        end
        OP_ROTL: begin
          q    <= {q[WIDTH-2:0], q[WIDTH-1]};
          sout <= q[WIDTH-1];
        end
        OP_ROTR: begin
          q    <= {q[0], q[WIDTH-1:1]};
          sout <= q[0];
        end
        OP_CLEAR: begin
          q    <= '0;
          sout <= 1'b0;
        end
        default: ;  // hold; burst start is mapped to OP_LOAD by the controller
      endcase
    end
  end

endmodule

// File: rtl/dreg_shifter.sv
// Shift/rotate register with a burst controller: a burst loads d and then
// shifts len times in the latched direction, pulsing done on completion.
module dreg_shifter
  import dreg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic [CNT_W-1:0] len,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic             dir_r, dir_n;
  logic             done_n;
  op_t              cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      dir_r     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      dir_r     <= dir_n;
      done      <= done_n;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    dir_n       = dir_r;
    done_n      = 1'b0;
    cmd         = OP_HOLD;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (op_t'(op) == OP_BURST) begin
            cmd         = OP_LOAD;
            dir_n       = dir;
            remaining_n = len;
            if (len != '0) state_n = ST_BUSY;
            else           done_n  = 1'b1;
          end else begin
            cmd = op_t'(op);
          end
        end
        ST_BUSY: begin
          if (op_t'(op) == OP_CLEAR) begin
            // abort: clear the register, drop the burst, no done pulse
            cmd         = OP_CLEAR;
            state_n     = ST_IDLE;
            remaining_n = '0;
          end else begin
            cmd         = dir_r ? OP_SHR : OP_SHL;
            remaining_n = remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_BUSY);

  dreg_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .cmd  (cmd),
    .d    (d),
    .sin  (sin),
    .q    (q),
    .sout (sout)
  );

endmodule
